// File: rtl/boid_pkg.sv
// Shared constants and state type for the boid update sequencer.
// The toroidal-boundary variant is selected by defining BOID_SEQ_WRAP_EN.
package boid_pkg;

  localparam int FRAC_BITS = 16;

  // Field widths as stored by the boid memory (x, y, vx, vy, accumulators).
  localparam int X_W   = 28;
  localparam int Y_W   = 27;
  localparam int VX_W  = 21;
  localparam int VY_W  = 21;
  localparam int ACC_W = 32;

  localparam logic [31:0] DEF_MAX_SPEED = 32'd8 << FRAC_BITS;
  localparam logic [31:0] DEF_X_MAX     = 32'd639 << FRAC_BITS;
  localparam logic [31:0] DEF_Y_MAX     = 32'd479 << FRAC_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VEL,
    S_POS,
    S_WRITE,
    S_DONE
  } boid_state_e;

endpackage

// File: rtl/boid_axis_integrator.sv
// One-axis fix16 integrator: saturating velocity add and position add with
// boundary handling (bounce by default, toroidal wrap with BOID_SEQ_WRAP_EN).
module boid_axis_integrator
  import boid_pkg::*;
(
  input  logic [31:0] pos,
  input  logic [31:0] vel,
  input  logic [31:0] acc,
  input  logic [31:0] max,
  input  logic [31:0] bound,
  output logic [31:0] vel_sat,
  output logic [31:0] pos_next,
  output logic [31:0] vel_next
);

  logic signed [32:0] v_sum;
  logic signed [32:0] p_sum;
  logic signed [32:0] max_s;
  logic signed [32:0] bound_s;
`ifdef BOID_SEQ_WRAP_EN
  logic signed [32:0] span;
  logic signed [32:0] p_wrap;
`endif

  always_comb begin
    max_s    = {1'b0, max};
    bound_s  = {1'b0, bound};
    v_sum    = {vel[31], vel} + {acc[31], acc};
    vel_sat  = v_sum[31:0];
    if (v_sum > max_s) begin
      vel_sat = max;
    end else if (v_sum < -max_s) begin
      vel_sat = 32'd0 - max;
    end

    // Position step uses vel as given; the caller feeds the saturated velocity here.
    p_sum    = {pos[31], pos} + {vel[31], vel};
    pos_next = p_sum[31:0];
    vel_next = vel;
`ifdef BOID_SEQ_WRAP_EN
    span   = bound_s + (33'sd1 <<< FRAC_BITS);
    p_wrap = p_sum;
    if (p_sum > bound_s) begin
      p_wrap = p_sum - span;
    end else if (p_sum < 33'sd0) begin
      p_wrap = p_sum + span;
    end
    pos_next = p_wrap[31:0];
`else
    if (p_sum > bound_s) begin
      pos_next = bound;
      vel_next = 32'd0 - vel;
    end else if (p_sum < 33'sd0) begin
      pos_next = '0;
      vel_next = 32'd0 - vel;
    end
`endif
  end

endmodule

// File: rtl/boid_update_sequencer.sv
// Per-frame boid update engine: walks every boid, integrates it and writes it back.
// BOID_SEQ_WRAP_EN selects toroidal instead of bouncing screen edges.
module boid_update_sequencer
  import boid_pkg::*;
#(
  parameter int          NUM_BOIDS = 2,
  parameter logic [31:0] MAX_SPEED = DEF_MAX_SPEED,
  parameter logic [31:0] X_MAX     = DEF_X_MAX,
  parameter logic [31:0] Y_MAX     = DEF_Y_MAX,
  localparam int         IW        = $clog2(NUM_BOIDS) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [IW-1:0]     which_boid,
  output logic [6:0]        wb_en,
  input  logic [31:0]       x_rd,
  input  logic [31:0]       y_rd,
  input  logic [31:0]       vx_rd,
  input  logic [31:0]       vy_rd,
  input  logic [31:0]       vx_acc_rd,
  input  logic [31:0]       vy_acc_rd,
  output logic [31:0]       x_wr,
  output logic [31:0]       y_wr,
  output logic [31:0]       vx_wr,
  output logic [31:0]       vy_wr,
  output logic [31:0]       vx_acc_wr,
  output logic [31:0]       vy_acc_wr,
  output boid_state_e       state_dbg
);

  // Handshake: start is honoured only in IDLE (pulse, no ready); busy covers
  // the cycle after start through done; done is a single-cycle completion pulse.
  boid_state_e state_q, state_d;
  logic [IW-1:0] idx_q;
  logic          last_boid;

  logic [31:0] x_q, y_q, vx_q, vy_q, vxa_q, vya_q;
  logic [31:0] vx_sat, vy_sat, x_next, y_next, vx_next, vy_next;

  assign last_boid  = (idx_q == IW'(NUM_BOIDS - 1));
  assign which_boid = idx_q;
  assign state_dbg  = state_q;
  assign vx_acc_wr  = '0;
  assign vy_acc_wr  = '0;

  boid_axis_integrator u_x_axis (
    .pos      (x_q),
    .vel      (vx_q),
    .acc      (vxa_q),
    .max      (MAX_SPEED),
    .bound    (X_MAX),
    .vel_sat  (vx_sat),
    .pos_next (x_next),
    .vel_next (vx_next)
  );

  boid_axis_integrator u_y_axis (
    .pos      (y_q),
    .vel      (vy_q),
    .acc      (vya_q),
    .max      (MAX_SPEED),
    .bound    (Y_MAX),
    .vel_sat  (vy_sat),
    .pos_next (y_next),
    .vel_next (vy_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    wb_en   = '0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = S_VEL;
      S_VEL:   state_d = S_POS;
      S_POS:   state_d = S_WRITE;
      S_WRITE: state_d = last_boid ? S_DONE : S_LOAD;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Outputs decode the state register so reset clears them asynchronously.
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
    if (state_q == S_WRITE) wb_en = 7'h7F;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      vx_q  <= '0;
      vy_q  <= '0;
      vxa_q <= '0;
      vya_q <= '0;
      x_wr  <= '0;
      y_wr  <= '0;
      vx_wr <= '0;
      vy_wr <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) idx_q <= '0;
        S_LOAD: begin
          x_q   <= x_rd;
          y_q   <= y_rd;
          vx_q  <= vx_rd;
          vy_q  <= vy_rd;
          vxa_q <= vx_acc_rd;
          vya_q <= vy_acc_rd;
        end
        S_VEL: begin
          vx_q <= vx_sat;
          vy_q <= vy_sat;
        end
        // Write data is captured once per boid and held until the next POS.
        S_POS: begin
          x_wr  <= x_next;
          y_wr  <= y_next;
          vx_wr <= vx_next;
          vy_wr <= vy_next;
        end
        S_WRITE: if (!last_boid) idx_q <= idx_q + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
